// File: rtl/q_hit_buffer.sv
// First-word-fall-through hit buffer: stores {charge, timestamp} for each finished
// charge pulse, counts hits lost to a full buffer, and supports a synchronous flush.
module q_hit_buffer #(
    parameter int BITS      = 31,
    parameter int TS_BITS   = 32,
    parameter int ADDR      = 4,
    parameter int DROP_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_in,
    input  logic signed [BITS-1:0] q_in,
    input  logic                   clear,
    input  logic                   m_ready,
    output logic                   m_valid,
    output logic signed [BITS-1:0] m_q,
    output logic [TS_BITS-1:0]     m_ts,
    output logic [ADDR:0]          level,
    output logic [DROP_BITS-1:0]   drop_count
);

    localparam int DEPTH = 2 ** ADDR;
    localparam int W     = BITS + TS_BITS;

    localparam logic [ADDR-1:0]    PTR_ONE  = 1;
    localparam logic [ADDR:0]      LVL_ONE  = 1;
    localparam logic [TS_BITS-1:0] TS_ONE   = 1;
    localparam logic [DROP_BITS-1:0] DROP_ONE = 1;

    logic [W-1:0]         mem_q [DEPTH];
    logic [ADDR-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]        level_q, level_d;
    logic [TS_BITS-1:0]   ts_q, ts_d;
    logic [DROP_BITS-1:0] drop_q, drop_d;
    logic                 pop, push, full;
    logic [W-1:0]         head;

    // level never exceeds DEPTH, so its MSB alone marks a full buffer.
    assign full = level_q[ADDR];
    assign pop  = m_valid && m_ready && !clear;
    assign push = valid_in && !clear && (!full || pop);

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        ts_d     = ts_q + TS_ONE;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            drop_d   = '0;
            ts_d     = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push && !pop)      level_d = level_q + LVL_ONE;
            else if (pop && !push) level_d = level_q - LVL_ONE;
            if (valid_in && !push && (drop_q != '1)) drop_d = drop_q + DROP_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            ts_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            ts_q     <= ts_d;
        end
    end

    // NOTE: storage has no reset; entries are only visible through level, which is reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {q_in, ts_q};
    end

    assign head       = mem_q[rd_ptr_q];
    assign m_valid    = (level_q != '0);
    assign m_q        = head[W-1:TS_BITS];
    assign m_ts       = head[TS_BITS-1:0];
    assign level      = level_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_q_hit_buffer.sv
// Randomized and directed bench for q_hit_buffer, checked against a queue-based model.
module tb_q_hit_buffer;

    localparam int BITS      = 31;
    localparam int TS_BITS   = 4;
    localparam int ADDR      = 4;
    localparam int DROP_BITS = 4;
    localparam int DEPTH     = 2 ** ADDR;
    localparam int DROP_MAX  = 2 ** DROP_BITS - 1;
    localparam int TS_MOD    = 2 ** TS_BITS;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   valid_in;
    logic signed [BITS-1:0] q_in;
    logic                   clear;
    logic                   m_ready;
    logic                   m_valid;
    logic signed [BITS-1:0] m_q;
    logic [TS_BITS-1:0]     m_ts;
    logic [ADDR:0]          level;
    logic [DROP_BITS-1:0]   drop_count;

    q_hit_buffer #(.BITS(BITS), .TS_BITS(TS_BITS), .ADDR(ADDR), .DROP_BITS(DROP_BITS)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .q_in(q_in), .clear(clear),
        .m_ready(m_ready), .m_valid(m_valid), .m_q(m_q), .m_ts(m_ts),
        .level(level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [BITS-1:0] q;
        int unsigned            ts;
    } ent_t;

    ent_t        mdl_q[$];
    int unsigned mdl_ts;
    int unsigned mdl_drops;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_ts    = 0;
        mdl_drops = 0;
    endtask

    task automatic compare_outputs(input string tag);
        check({tag, ".level"},   64'(level),      64'(mdl_q.size()));
        check({tag, ".m_valid"}, 64'(m_valid),    64'(mdl_q.size() != 0));
        check({tag, ".drops"},   64'(drop_count), 64'(mdl_drops));
        if (mdl_q.size() != 0) begin
            check({tag, ".m_q"},  64'(m_q),  64'(mdl_q[0].q));
            check({tag, ".m_ts"}, 64'(m_ts), 64'(mdl_q[0].ts));
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance model across the rising edge.
    task automatic cycle(input string tag, input logic v, input logic signed [BITS-1:0] q,
                         input logic rdy, input logic clr);
        bit   pop, acc;
        ent_t e;
        compare_outputs(tag);
        valid_in = v;
        q_in     = q;
        m_ready  = rdy;
        clear    = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            pop = (mdl_q.size() != 0) && rdy;
            acc = v && ((mdl_q.size() < DEPTH) || pop);
            if (pop) void'(mdl_q.pop_front());
            if (acc) begin
                e.q  = q;
                e.ts = mdl_ts;
                mdl_q.push_back(e);
            end else if (v && mdl_drops < DROP_MAX) begin
                mdl_drops++;
            end
            mdl_ts = (mdl_ts + 1) % TS_MOD;
        end
        @(negedge clk);
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic idle(input string tag, input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        q_in     = '0;
        clear    = 1'b0;
        m_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.m_valid", 64'(m_valid), 64'd0);
        check("reset.level",   64'(level),   64'd0);
        check("reset.drops",   64'(drop_count), 64'd0);
        reset_n = 1'b1;

        // Single hit at timestamp 10 with downstream always ready.
        idle("single.idle", 10, 1'b1);
        cycle("single.push", 1'b1, -31'sd5, 1'b1, 1'b0);
        check("single.valid", 64'(m_valid), 64'd1);
        check("single.q",     64'(m_q),     64'(-31'sd5));
        check("single.ts",    64'(m_ts),    64'd10);
        cycle("single.pop", 1'b0, '0, 1'b1, 1'b0);
        check("single.level0", 64'(level), 64'd0);
        check("single.valid0", 64'(m_valid), 64'd0);

        // Fill past full with no consumer, then drain in order.
        for (int i = 1; i <= 18; i++) cycle("fill", 1'b1, 31'(i), 1'b0, 1'b0);
        check("fill.level", 64'(level), 64'd16);
        check("fill.drops", 64'(drop_count), 64'd2);
        for (int i = 1; i <= 16; i++) begin
            check("drain.order", 64'(m_q), 64'(31'(i)));
            cycle("drain", 1'b0, '0, 1'b1, 1'b0);
        end
        check("drain.empty", 64'(m_valid), 64'd0);

        // Full buffer: push together with a pop keeps level at DEPTH.
        for (int i = 0; i < 16; i++) cycle("full.fill", 1'b1, 31'(100 + i), 1'b0, 1'b0);
        cycle("full.pushpop", 1'b1, 31'd777, 1'b1, 1'b0);
        check("full.level", 64'(level), 64'd16);
        check("full.drops", 64'(drop_count), 64'd2);
        idle("full.drain", 15, 1'b1);
        check("full.last", 64'(m_q), 64'd777);
        idle("full.drain2", 1, 1'b1);

        // Backpressure: ready toggles every cycle; model checks head stability.
        for (int i = 0; i < 3; i++) cycle("bp.fill", 1'b1, 31'(-200 - i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle("bp.toggle", 1'b0, '0, 1'(i % 2), 1'b0);
        check("bp.empty", 64'(level), 64'd0);

        // Clear during a push with 5 entries, then timestamp wrap.
        for (int i = 0; i < 5; i++) cycle("clr.fill", 1'b1, 31'(i), 1'b0, 1'b0);
        cycle("clr.clear", 1'b1, 31'd99, 1'b0, 1'b1);
        check("clr.level", 64'(level), 64'd0);
        check("clr.drops", 64'(drop_count), 64'd0);
        check("clr.valid", 64'(m_valid), 64'd0);
        idle("clr.idle", 17, 1'b0);
        cycle("clr.hit", 1'b1, 31'd42, 1'b0, 1'b0);
        check("clr.wrap_ts", 64'(m_ts), 64'd1);

        // Async reset mid-drain with 7 entries left.
        cycle("rst.clear", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle("rst.fill", 1'b1, 31'(50 + i), 1'b0, 1'b0);
        idle("rst.drain", 2, 1'b1);
        check("rst.level7", 64'(level), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check("rst.async_valid", 64'(m_valid), 64'd0);
        check("rst.async_level", 64'(level), 64'd0);
        model_reset();
        valid_in = 1'b1;
        q_in     = 31'd5;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        check("rst.hold_level", 64'(level), 64'd0);
        reset_n = 1'b1;
        idle("rst.resume", 3, 1'b1);
        cycle("rst.push", 1'b1, 31'd9, 1'b0, 1'b0);
        check("rst.ts_resume", 64'(m_ts), 64'd3);
        idle("rst.flush", 1, 1'b1);

        // Randomized traffic with varying consumer pressure and rare clears.
        for (int i = 0; i < 3000; i++) begin
            logic v, r, c;
            v = 1'($urandom % 2);
            r = (i < 1000) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            c = ($urandom % 200 == 0);
            cycle("rand", v, 31'($urandom), r, c);
        end

        // Drop counter saturation.
        cycle("sat.clear", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cycle("sat.fill", 1'b1, 31'(i), 1'b0, 1'b0);
        check("sat.drops", 64'(drop_count), 64'(DROP_MAX));
        check("sat.level", 64'(level), 64'd16);
        idle("sat.end", 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
